// File: rtl/mc_ctrl_fsm_ws.sv
// mc_ctrl_fsm_ws
// Multicycle control unit for the 4-bit-opcode datapath, with memory
// wait-state handshake, bus-timeout and illegal-opcode trapping, resume from
// halt, and cycle / retired-instruction counters.
//
// Ports
//   clock, reset         rising-edge clock, async active-high reset
//   instr, instr_regs    IR opcode and IR[7:4] (stop/nop decode)
//   N, Z                 flags for conditional branches
//   mem_ready            memory finishes the access this cycle
//   resume               leave STOP/FAULT
//   PCwrite..FlagWrite   1-bit datapath controls
//   ALU2, ALUop          ALU B-source select and ALU operation
//   cycle_count          cycles executed (frozen while halted)
//   instr_count          instructions fetched
//   halted, fault        halt flag and fault cause (01 illegal, 10 timeout)
//   state_out            current state encoding
//
// state  | meaning
// RESET  | out of reset, go fetch
// FETCH  | read instruction, wait for mem_ready
// DECODE | load R1/R2, dispatch on opcode
// ASN3   | add/sub/nand execute
// ASNSH4 | write back ALU result
// SHIFT3 | shift execute
// ORI3   | select R1 as source
// ORI4   | or-immediate execute
// ORI5   | write back to R1
// LOAD3  | memory read, wait for mem_ready
// LOAD4  | write MDR to register file
// STORE3 | memory write, wait for mem_ready
// BPZ3   | branch if not negative
// BZ3    | branch if zero
// BNZ3   | branch if not zero
// NOP    | idle one cycle
// STOP   | halted by program, wait for resume
// FAULT  | halted by trap, wait for resume
module mc_ctrl_fsm_ws #(
    parameter int CYC_W       = 8,
    parameter int INSTR_W     = 8,
    parameter int SAT         = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         instr,
    input  logic [3:0]         instr_regs,
    input  logic               N,
    input  logic               Z,
    input  logic               mem_ready,
    input  logic               resume,
    output logic               PCwrite,
    output logic               AddrSel,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRload,
    output logic               R1Sel,
    output logic               MDRload,
    output logic               R1R2Load,
    output logic               ALU1,
    output logic               ALUOutWrite,
    output logic               RFWrite,
    output logic               RegIn,
    output logic               FlagWrite,
    output logic [2:0]         ALU2,
    output logic [2:0]         ALUop,
    output logic [CYC_W-1:0]   cycle_count,
    output logic [INSTR_W-1:0] instr_count,
    output logic               halted,
    output logic [1:0]         fault,
    output logic [4:0]         state_out
);

    typedef enum logic [4:0] {
        S_RESET  = 5'd0,
        S_FETCH  = 5'd1,
        S_DECODE = 5'd2,
        S_ASN3   = 5'd3,
        S_ASNSH4 = 5'd4,
        S_SHIFT3 = 5'd5,
        S_ORI3   = 5'd6,
        S_ORI4   = 5'd7,
        S_ORI5   = 5'd8,
        S_LOAD3  = 5'd9,
        S_LOAD4  = 5'd10,
        S_STORE3 = 5'd11,
        S_BPZ3   = 5'd12,
        S_BZ3    = 5'd13,
        S_BNZ3   = 5'd14,
        S_NOP    = 5'd15,
        S_STOP   = 5'd16,
        S_FAULT  = 5'd17
    } state_t;

    localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);
    localparam bit         TO_EN  = (MEM_TIMEOUT != 0);

    state_t               state_q, state_d;
    logic [7:0]           wait_q, wait_d;
    logic [1:0]           fault_q, fault_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic [INSTR_W-1:0]   ins_q, ins_d;

    logic       mem_state;
    logic       halt_state;
    logic [8:0] wait_inc;
    logic       timeout;

    assign mem_state  = (state_q == S_FETCH) || (state_q == S_LOAD3) || (state_q == S_STORE3);
    assign halt_state = (state_q == S_STOP) || (state_q == S_FAULT);
    // wait_q counts earlier stalled cycles; +1 includes the current one, so
    // MEM_TIMEOUT stalled cycles in a row trap on the last of them.
    assign wait_inc   = {1'b0, wait_q} + 9'd1;
    assign timeout    = TO_EN && mem_state && !mem_ready && (wait_inc == TO_LIM);

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (instr == 4'b0100 || instr == 4'b0110 || instr == 4'b1000)
                    state_d = S_ASN3;
                else if (instr[2:0] == 3'b011)
                    state_d = S_SHIFT3;
                else if (instr[2:0] == 3'b111)
                    state_d = S_ORI3;
                else if (instr == 4'b0000)
                    state_d = S_LOAD3;
                else if (instr == 4'b0010)
                    state_d = S_STORE3;
                else if (instr == 4'b1101)
                    state_d = S_BPZ3;
                else if (instr == 4'b0101)
                    state_d = S_BZ3;
                else if (instr == 4'b1001)
                    state_d = S_BNZ3;
                else if (instr == 4'b0001 && instr_regs == 4'b0000)
                    state_d = S_STOP;
                else if (instr == 4'b0001 && instr_regs == 4'b1000)
                    state_d = S_NOP;
                else begin
                    state_d = S_FAULT;
                    fault_d = 2'b01;
                end
            end
            S_ASN3, S_SHIFT3: state_d = S_ASNSH4;
            S_ASNSH4: state_d = S_FETCH;
            S_ORI3:   state_d = S_ORI4;
            S_ORI4:   state_d = S_ORI5;
            S_ORI5:   state_d = S_FETCH;
            S_LOAD3:  if (mem_ready) state_d = S_LOAD4;
            S_LOAD4:  state_d = S_FETCH;
            S_STORE3: if (mem_ready) state_d = S_FETCH;
            S_BPZ3, S_BZ3, S_BNZ3, S_NOP: state_d = S_FETCH;
            S_STOP, S_FAULT: begin
                if (resume) begin
                    state_d = S_FETCH;
                    fault_d = 2'b00;
                end
            end
            default:  state_d = S_RESET;
        endcase
        if (timeout) begin
            state_d = S_FAULT;
            fault_d = 2'b10;
        end
    end

    // Counter is zero outside memory states, so every entry starts from zero.
    always_comb begin
        wait_d = 8'd0;
        if (mem_state && !mem_ready && !timeout)
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
    end

    always_comb begin
        cyc_d = cyc_q;
        if (!halt_state) begin
            if (&cyc_q)
                cyc_d = (SAT != 0) ? cyc_q : '0;
            else
                cyc_d = cyc_q + CYC_W'(1);
        end
        ins_d = ins_q;
        if (state_q == S_FETCH && state_d == S_DECODE) begin
            if (&ins_q)
                ins_d = (SAT != 0) ? ins_q : '0;
            else
                ins_d = ins_q + INSTR_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            wait_q  <= 8'd0;
            fault_q <= 2'b00;
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
        end
    end

    // Controls follow the current state (plus flags / mem_ready) so that an
    // asserted reset silences them in the same cycle.
    always_comb begin
        PCwrite     = 1'b0;
        AddrSel     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRload      = 1'b0;
        R1Sel       = 1'b0;
        MDRload     = 1'b0;
        R1R2Load    = 1'b0;
        ALU1        = 1'b0;
        ALUOutWrite = 1'b0;
        RFWrite     = 1'b0;
        RegIn       = 1'b0;
        FlagWrite   = 1'b0;
        ALU2        = 3'b000;
        ALUop       = 3'b000;
        case (state_q)
            S_FETCH: begin
                AddrSel = 1'b1;
                MemRead = 1'b1;
                ALU2    = 3'b001;
                PCwrite = mem_ready;
                IRload  = mem_ready;
            end
            S_DECODE: R1R2Load = 1'b1;
            S_ASN3: begin
                ALU1        = 1'b1;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
                case (instr)
                    4'b0110: ALUop = 3'b001;
                    4'b1000: ALUop = 3'b011;
                    default: ALUop = 3'b000;
                endcase
            end
            S_SHIFT3: begin
                ALU1        = 1'b1;
                ALU2        = 3'b100;
                ALUop       = 3'b100;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_ASNSH4: RFWrite = 1'b1;
            S_ORI3: begin
                R1Sel    = 1'b1;
                R1R2Load = 1'b1;
            end
            S_ORI4: begin
                ALU1        = 1'b1;
                ALU2        = 3'b011;
                ALUop       = 3'b010;
                ALUOutWrite = 1'b1;
                FlagWrite   = 1'b1;
            end
            S_ORI5: begin
                R1Sel   = 1'b1;
                RFWrite = 1'b1;
            end
            S_LOAD3: begin
                MemRead = 1'b1;
                MDRload = mem_ready;
            end
            S_LOAD4: begin
                ALUOutWrite = 1'b1;
                RFWrite     = 1'b1;
                RegIn       = 1'b1;
            end
            S_STORE3: MemWrite = 1'b1;
            S_BPZ3: begin
                ALU2    = 3'b010;
                PCwrite = ~N;
            end
            S_BZ3: begin
                ALU2    = 3'b010;
                PCwrite = Z;
            end
            S_BNZ3: begin
                ALU2    = 3'b010;
                PCwrite = ~Z;
            end
            default: ;
        endcase
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
    assign halted      = halt_state;
    assign fault       = fault_q;
    assign state_out   = state_q;

endmodule

// File: doc/mc_ctrl_fsm_ws.md
Name: mc_ctrl_fsm_ws

Overview:
Second-generation multicycle control unit for the 4-bit-opcode processor datapath. It issues the same datapath control set as the current control FSM and adds:
- memory wait-state handshake (mem_ready), with a parametrised timeout;
- illegal-opcode and bus-timeout fault trapping, plus resume from halt;
- parametrised saturating/wrapping cycle and retired-instruction counters.

It sits between the IR/flag registers and the datapath.

Parameters:
CYC_W, 8, cycle counter width
INSTR_W, 8, retired-instruction counter width
SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap
MEM_TIMEOUT, 15, max wait cycles per memory state (1..255); 0 disables timeout

Ports:
clock  in  1  clock, rising edge
reset  in  1  reset, asynchronous, active-high
instr  in  4  opcode from IR
instr_regs  in  4  IR[7:4], used for stop/nop decode
N  in  1  negative flag
Z  in  1  zero flag
mem_ready  in  1  memory completes access this cycle
resume  in  1  leave STOP/FAULT
PCwrite, AddrSel, MemRead, MemWrite, IRload, R1Sel, MDRload, R1R2Load, ALU1, ALUOutWrite, RFWrite, RegIn, FlagWrite  out  1 each  datapath controls
ALU2  out  3  ALU B-source select
ALUop  out  3  ALU operation
cycle_count  out  CYC_W  cycles executed
instr_count  out  INSTR_W  instructions fetched
halted  out  1  state is STOP or FAULT
fault  out  2  00 none, 01 illegal opcode, 10 memory timeout
state_out  out  5  current state encoding

Behaviour:
Reset:
- state = RESET; all controls, ALU2, ALUop, counters, fault and wait counter = 0.

State encoding:
- RESET 0, FETCH 1, DECODE 2, ASN3 3, ASNSH4 4, SHIFT3 5, ORI3 6, ORI4 7, ORI5 8, LOAD3 9, LOAD4 10, STORE3 11, BPZ3 12, BZ3 13, BNZ3 14, NOP 15, STOP 16, FAULT 17.

Transitions:
- RESET -> FETCH.
- FETCH -> DECODE when mem_ready, else stay.
- DECODE decode, first match wins:
  - instr 0100/0110/1000 -> ASN3
  - instr[2:0] = 011 -> SHIFT3
  - instr[2:0] = 111 -> ORI3
  - 0000 -> LOAD3
  - 0010 -> STORE3
  - 1101 -> BPZ3
  - 0101 -> BZ3
  - 1001 -> BNZ3
  - 0001 with instr_regs = 0000 -> STOP
  - 0001 with instr_regs = 1000 -> NOP
  - anything else -> FAULT, fault = 01
- ASN3, SHIFT3 -> ASNSH4 -> FETCH.
- ORI3 -> ORI4 -> ORI5 -> FETCH.
- LOAD3 -> LOAD4 when mem_ready, else stay; LOAD4 -> FETCH.
- STORE3 -> FETCH when mem_ready, else stay.
- BPZ3, BZ3, BNZ3, NOP -> FETCH.
- STOP, FAULT: stay; resume = 1 -> FETCH next edge, fault cleared.

Memory timeout (FETCH, LOAD3, STORE3):
- An 8-bit wait counter clears on entry and increments each cycle mem_ready = 0.
- If MEM_TIMEOUT != 0 and the counter equals MEM_TIMEOUT while mem_ready = 0 -> FAULT next edge, fault = 10.
- If mem_ready = 1 on the timeout cycle, the access completes normally; no fault.

Outputs (combinational from state, N, Z, mem_ready; every signal not listed = 0, ALU2/ALUop = 000):
- FETCH: AddrSel, MemRead, ALU2 = 001; PCwrite and IRload = mem_ready.
- DECODE: R1R2Load.
- ASN3: ALU1, ALUOutWrite, FlagWrite; ALUop = 000 add (0100), 001 sub (0110), 011 nand (1000).
- SHIFT3: ALU1, ALU2 = 100, ALUop = 100, ALUOutWrite, FlagWrite.
- ASNSH4: RFWrite.
- ORI3: R1Sel, R1R2Load.
- ORI4: ALU1, ALU2 = 011, ALUop = 010, ALUOutWrite, FlagWrite.
- ORI5: R1Sel, RFWrite.
- LOAD3: MemRead; MDRload = mem_ready.
- LOAD4: ALUOutWrite, RFWrite, RegIn.
- STORE3: MemWrite held until mem_ready.
- BPZ3: ALU2 = 010, PCwrite = ~N.
- BZ3: ALU2 = 010, PCwrite = Z.
- BNZ3: ALU2 = 010, PCwrite = ~Z.
- NOP, STOP, FAULT, RESET: all zero.

Counters:
- cycle_count increments on every edge where the current state is neither STOP nor FAULT.
- instr_count increments on the FETCH->DECODE edge.
- At all-ones: hold if SAT = 1, wrap to 0 if SAT = 0.
- Both counters hold in STOP/FAULT and do not clear on resume.

Other:
- halted = 1 iff state is STOP or FAULT.
- resume is ignored outside STOP/FAULT.
- Reset asserted mid-instruction returns to RESET immediately; no partial writes are issued after assertion.

Test Plan:
1. ADD (0100), mem_ready tied 1, from reset -> states 0,1,2,3,4,1. ALU1/ALUOutWrite/FlagWrite in ASN3, RFWrite in ASNSH4. cycle_count = 5 at second FETCH; instr_count = 1.
2. FETCH with mem_ready low 3 cycles, MEM_TIMEOUT = 15 -> FETCH held 4 cycles. MemRead = 1 throughout; PCwrite/IRload = 1 only on the 4th cycle; no fault.
3. STORE (0010), mem_ready never high, MEM_TIMEOUT = 4 -> FAULT entered after 4 STORE3 cycles with fault = 10 and halted = 1. resume pulse -> FETCH next cycle, fault = 00.
4. Opcode 1111 with instr[2:0] = 111 -> ORI path 6,7,8. Opcode 0001 with instr_regs = 0011 -> FAULT, fault = 01; cycle_count frozen over 10 cycles.
5. BZ (0101) with Z = 1 -> PCwrite = 1, ALU2 = 010. BPZ (1101) with N = 1 -> PCwrite = 0. STOP (0001/0000) -> halted = 1, counters frozen.
6. CYC_W = 4, SAT = 1, long NOP loop -> cycle_count holds at 15. Same run with SAT = 0 -> wraps 15 -> 0. Reset asserted in LOAD3 -> all outputs 0 the same cycle.
